// File: rtl/gen_pipe_reg.sv
`timescale 1ns/1ps
// Pipeline register stage with valid/ready handshake; SKID=1 adds a second
// entry so in_ready_o comes straight from a flop.
module gen_pipe_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               SKID    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;

  assign out_valid_o = (r_state != ST_EMPTY);
  assign out_data_o  = r_main;
  assign count_o     = r_state;
  assign in_ready_o  = w_in_ready;
  assign w_in_fire   = in_valid_i & w_in_ready;
  assign w_out_fire  = out_valid_o & out_ready_i;

  // Occupancy: flush wins over everything, the illegal code falls back to EMPTY.
  always_comb begin
    w_state_nxt = ST_EMPTY;
    if (!flush_i) begin
      case (r_state)
        ST_EMPTY: w_state_nxt = w_in_fire ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire && SKID)
            w_state_nxt = ST_TWO;
          else if (!w_in_fire && w_out_fire)
            w_state_nxt = ST_EMPTY;
          else
            w_state_nxt = ST_ONE;
        end
        ST_TWO:   w_state_nxt = w_out_fire ? ST_ONE : ST_TWO;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] r_skid;
      logic             r_in_ready;

      assign w_in_ready = r_in_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_in_ready <= 1'b1;
          r_skid     <= RST_VAL;
          r_main     <= RST_VAL;
        end else begin
          r_in_ready <= (w_state_nxt != ST_TWO);
          if (!flush_i) begin
            // main always holds the oldest entry; skid only fills behind it
            if (r_state == ST_TWO && w_out_fire)
              r_main <= r_skid;
            else if (w_in_fire && (r_state == ST_EMPTY || (r_state == ST_ONE && w_out_fire)))
              r_main <= in_data_i;
            if (r_state == ST_ONE && w_in_fire && !w_out_fire)
              r_skid <= in_data_i;
          end
        end
      end
    end else begin : g_single
      assign w_in_ready = ~out_valid_o | out_ready_i;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_main <= RST_VAL;
        else if (!flush_i && w_in_fire) r_main <= in_data_i;
      end
    end
  endgenerate

endmodule

// File: tb/tb_gen_pipe_reg.sv
`timescale 1ns/1ps
// Bench for gen_pipe_reg: SKID=0 and SKID=1 instances side by side, each
// checked every cycle against a queue scoreboard.
module tb_gen_pipe_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] flush;
  logic [1:0] in_valid;
  logic [1:0] out_ready;
  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [7:0] in_data  [2];
  logic [7:0] out_data [2];
  logic [1:0] count    [2];

  logic [7:0] sb [2][$];
  bit         hold   [2];
  logic [7:0] hold_d [2];
  bit         acc    [2];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  gen_pipe_reg #(.WIDTH(8), .RST_VAL(8'hA5), .SKID(1'b0)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush[0]),
    .in_valid_i  (in_valid[0]),
    .in_data_i   (in_data[0]),
    .in_ready_o  (in_ready[0]),
    .out_valid_o (out_valid[0]),
    .out_data_o  (out_data[0]),
    .out_ready_i (out_ready[0]),
    .count_o     (count[0])
  );

  gen_pipe_reg #(.WIDTH(8), .RST_VAL(8'hA5), .SKID(1'b1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush[1]),
    .in_valid_i  (in_valid[1]),
    .in_data_i   (in_data[1]),
    .in_ready_o  (in_ready[1]),
    .out_valid_o (out_valid[1]),
    .out_data_o  (out_data[1]),
    .out_ready_i (out_ready[1]),
    .count_o     (count[1])
  );

  task automatic chk(input string tag, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", tag, d, act, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, check outputs, advance the model
  // with the transfers that the next rising edge will perform.
  task automatic step(input logic [1:0] fl, input logic [1:0] iv, input logic [1:0] ordy,
                      input logic [7:0] d0, input logic [7:0] d1);
    int sz;
    bit erdy;
    @(negedge clk);
    flush = fl; in_valid = iv; out_ready = ordy;
    in_data[0] = d0; in_data[1] = d1;
    #1;
    for (int d = 0; d < 2; d++) begin
      sz   = sb[d].size();
      erdy = (d == 1) ? (sz < 2) : (sz == 0 || ordy[d]);
      chk("count", d, 32'(count[d]), 32'(sz));
      chk("out_valid", d, 32'(out_valid[d]), 32'(sz != 0));
      chk("in_ready", d, 32'(in_ready[d]), 32'(erdy));
      if (sz != 0) chk("out_data", d, 32'(out_data[d]), 32'(sb[d][0]));
      if (hold[d]) chk("hold_data", d, 32'(out_data[d]), 32'(hold_d[d]));
      hold[d]   = (sz != 0) && !ordy[d] && !fl[d];
      if (sz != 0) hold_d[d] = sb[d][0];
      acc[d]    = iv[d] && erdy && !fl[d];
      if (sz != 0 && ordy[d]) void'(sb[d].pop_front());
      if (fl[d]) sb[d].delete();
      else if (acc[d]) sb[d].push_back(d == 1 ? d1 : d0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    flush = '0; in_valid = '0; out_ready = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_count", d, 32'(count[d]), 32'd0);
      chk("rst_valid", d, 32'(out_valid[d]), 32'd0);
      chk("rst_data", d, 32'(out_data[d]), 32'hA5);
      sb[d].delete();
      hold[d] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("rst_in_ready", d, 32'(in_ready[d]), 32'd1);
  endtask

  initial begin
    logic [1:0] r_fl, r_iv, r_or;
    int n;
    rst_n = 1'b1;
    flush = '0; in_valid = '0; out_ready = '0;
    in_data[0] = '0; in_data[1] = '0;
    for (int d = 0; d < 2; d++) begin hold[d] = 1'b0; hold_d[d] = '0; acc[d] = 1'b0; end

    do_reset();

    for (int i = 1; i <= 16; i++) step(2'b00, 2'b11, 2'b11, 8'(i), 8'(i));
    repeat (3) step(2'b00, 2'b00, 2'b11, 8'h00, 8'h00);

    // skid stage filling under backpressure, then draining in order
    step(2'b00, 2'b10, 2'b01, 8'h00, 8'h11);
    step(2'b00, 2'b10, 2'b01, 8'h00, 8'h22);
    repeat (3) step(2'b00, 2'b10, 2'b01, 8'h00, 8'h33);
    chk("skid_full", 1, 32'(count[1]), 32'd2);
    n = 0;
    do begin
      step(2'b00, 2'b10, 2'b11, 8'h00, 8'h33);
      n++;
    end while (!acc[1] && n < 10);
    chk("accept_33_bound", 1, 32'(n < 10), 32'd1);
    repeat (4) step(2'b00, 2'b00, 2'b11, 8'h00, 8'h00);

    // single stage: blocked when full, then simultaneous in/out transfer
    step(2'b00, 2'b01, 2'b10, 8'h55, 8'h00);
    step(2'b00, 2'b01, 2'b10, 8'h66, 8'h00);
    step(2'b00, 2'b01, 2'b11, 8'h66, 8'h00);
    step(2'b00, 2'b00, 2'b10, 8'h00, 8'h00);
    chk("swap_count", 0, 32'(count[0]), 32'd1);
    chk("swap_data", 0, 32'(out_data[0]), 32'h66);
    repeat (2) step(2'b00, 2'b00, 2'b11, 8'h00, 8'h00);

    // flush a full skid stage while 0x44 is offered
    step(2'b00, 2'b10, 2'b00, 8'h00, 8'h70);
    step(2'b00, 2'b10, 2'b00, 8'h00, 8'h71);
    step(2'b10, 2'b10, 2'b00, 8'h00, 8'h44);
    repeat (3) step(2'b00, 2'b00, 2'b11, 8'h00, 8'h00);

    for (int c = 0; c < 10000; c++) begin
      r_fl[0] = ($urandom_range(0, 31) == 0);
      r_fl[1] = ($urandom_range(0, 31) == 0);
      r_iv    = 2'($urandom);
      r_or    = 2'($urandom);
      step(r_fl, r_iv, r_or, 8'($urandom), 8'($urandom));
    end

    // asynchronous reset with entries in flight
    step(2'b00, 2'b11, 2'b00, 8'h9C, 8'h9D);
    step(2'b00, 2'b11, 2'b00, 8'h9E, 8'h9F);
    do_reset();
    repeat (3) step(2'b00, 2'b11, 2'b11, 8'h3C, 8'h3D);
    repeat (3) step(2'b00, 2'b00, 2'b11, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gen_pipe_reg.md
Name: gen_pipe_reg

Overview:
Parametrised pipeline register stage with a valid/ready handshake. It replaces plain hold-controlled flops between CPU pipeline stages.
- Stall propagates as backpressure (out_ready_i low) rather than through a global hold.
- flush_i kills the in-flight entry.
- An optional 2-entry skid buffer registers in_ready_o, which breaks the combinational ready chain across stages.
- Full throughput (1 transfer/cycle) in both modes.

Parameters:
WIDTH, 32, payload width in bits.
RST_VAL, 0, reset value of all payload registers (WIDTH bits).
SKID, 0, 0 = single-entry stage with combinational in_ready_o; 1 = two-entry skid stage with registered in_ready_o.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
flush_i  input  1  synchronous flush; discards all stored entries.
in_valid_i  input  1  upstream data valid.
in_data_i  input  WIDTH  upstream payload.
in_ready_o  output  1  stage can accept; a transfer happens when in_valid_i & in_ready_o.
out_valid_o  output  1  stage holds valid data.
out_data_o  output  WIDTH  payload presented downstream.
out_ready_i  input  1  downstream accepts; a transfer happens when out_valid_o & out_ready_i.
count_o  output  2  current occupancy: 0, 1, or 2 (2 only when SKID=1).

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY, out_valid_o=0, count_o=0, main and skid registers = RST_VAL.
- After reset, in_ready_o=1 (both modes).
- Terms: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- Latency: data accepted at edge N appears on out_data_o/out_valid_o after edge N (1 cycle). No combinational in→out data path.
- Stability: while out_valid_o & ~out_ready_i, out_data_o and out_valid_o hold unchanged.
- Payload registers load only on the transfers listed below. No other enable; no reset on flush.
- SKID=0, states EMPTY/ONE:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - EMPTY: in_fire → main<=in_data_i, go ONE.
  - ONE: in_fire (with or without out_fire) → main<=in_data_i, stay ONE. out_fire only → EMPTY.
- SKID=1, states EMPTY/ONE/TWO:
  - in_ready_o is a flop output, 1 iff next state != TWO.
  - EMPTY: in_fire → main<=in, go ONE.
  - ONE, both fire → main<=in, stay ONE.
  - ONE, in_fire only → skid<=in, go TWO.
  - ONE, out_fire only → EMPTY.
  - TWO: in_ready_o=0; out_fire → main<=skid, go ONE.
  - Ordering: FIFO order preserved, main is always the oldest entry.
- out_valid_o = (state != EMPTY); count_o follows the state encoding.
- Flush (flush_i=1 at an edge): highest priority.
  - Next state EMPTY; out_valid_o=0 and count_o=0 next cycle; in_ready_o=1 next cycle.
  - An in_fire in the same cycle is dropped. Upstream is flushed by the same control.
  - An out_fire in the same cycle stands as completed.
  - Payload registers keep their values.
- Reset mid-transfer: state returns to EMPTY immediately (asynchronous); no partial transfer is retained.
- in_data_i is don't-care when in_valid_i=0. It is never captured because in_fire=0.
- State encoding: 2-bit, EMPTY=0, ONE=1, TWO=2; 3 is illegal and recovers to EMPTY.

Decomposition:
- No new shared package. RST_VAL replaces the global zero constant for this block.
- State encoding lives in local parameters inside the module.
- No sub-module. Control and data path are small, and the SKID variants are selected with a generate branch inside gen_pipe_reg.

Test Plan:
1. Reset: WIDTH=8, RST_VAL=8'hA5, pulse rst_n low mid-cycle → out_valid_o=0, out_data_o=8'hA5, count_o=0, in_ready_o=1 after release.
2. Streaming, SKID=0 and 1: feed 0x01..0x10 back-to-back with out_ready_i=1 → outputs 0x01..0x10 in order, one per cycle, 1-cycle latency, no bubbles.
3. Backpressure, SKID=1: hold out_ready_i=0 while sending 0x11, 0x22, 0x33 → count_o reaches 2, in_ready_o drops the cycle after 0x22 is accepted, and 0x33 is held off. Release out_ready_i → 0x11, 0x22, 0x33 delivered in order.
4. Backpressure, SKID=0: out_ready_i=0 with the stage full → in_ready_o=0 in the same cycle. Raise out_ready_i with in_valid_i=1 → simultaneous in/out transfer, count_o stays 1.
5. Flush: SKID=1, count_o=2, assert flush_i together with in_valid_i=1 (data 0x44) → next cycle out_valid_o=0, count_o=0, in_ready_o=1, and 0x44 is never output.
6. Random: random valid/ready/flush for 10k cycles against a reference queue model → no loss, duplication or reorder except entries flushed, and the stability rule is never violated.
